// File: rtl/effect_ctrl_pkg.sv
// Shared constants, state type and direction helper for the AXIS effect controller.
package effect_ctrl_pkg;

    localparam int GAIN_WIDTH     = 25;
    localparam int GAIN_FRAC_BITS = 24;
    localparam logic [GAIN_WIDTH-1:0] GAIN_ONE = 25'h1000000;

    typedef enum logic [1:0] {
        HOLD      = 2'd0,
        RAMP_UP   = 2'd1,
        RAMP_DOWN = 2'd2
    } gain_state_t;

    function automatic gain_state_t gain_dir(input logic [GAIN_WIDTH-1:0] g,
                                             input logic [GAIN_WIDTH-1:0] t);
        if (g < t) return RAMP_UP;
        if (g > t) return RAMP_DOWN;
        return HOLD;
    endfunction

endpackage

// File: rtl/axis_effect_controller_btn_debounce.sv
// Button synchroniser plus stability counter; btn_db follows btn only after
// DEBOUNCE_CYCLES consecutive cycles of disagreement, press marks its rising edge.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic btn_db,
    output logic press
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             btn_meta;
    logic             btn_sync;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
            cnt      <= '0;
            btn_db   <= 1'b0;
            press    <= 1'b0;
        end else begin
            btn_meta <= btn;
            btn_sync <= btn_meta;
            press    <= 1'b0;
            // A single-bit input that changes while disagreeing must fall back into agreement.
            if (btn_sync == btn_db) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt    <= '0;
                btn_db <= btn_sync;
                press  <= btn_sync;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/axis_effect_controller.sv
// Volume/clip configuration sequencer for the I2S2 AXIS datapath; settings change only on frame ticks.
// Optional build macro CLIP_TOGGLE_EN: button press toggles clipping instead of hold-to-clip.
//
//   state     | meaning
//   ----------+--------------------------------------------------
//   HOLD      | gain equals target, nothing to do
//   RAMP_UP   | gain below target, step up on each frame_tick
//   RAMP_DOWN | gain above target, step down on each frame_tick
module axis_effect_controller #(
    parameter int                    SWITCH_WIDTH    = 4,
    parameter int                    DATA_WIDTH      = 24,
    parameter int                    GAIN_WIDTH      = 25,
    parameter logic [GAIN_WIDTH-1:0] GAIN_STEP       = 25'h010000,
    parameter logic [DATA_WIDTH-1:0] CLIP_THRESH     = 24'h0F0000,
    parameter int                    DEBOUNCE_CYCLES = 1000000
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    btn,
    input  logic [SWITCH_WIDTH-1:0] sw,
    input  logic                    frame_tick,
    output logic [GAIN_WIDTH-1:0]   gain,
    output logic                    clip_en,
    output logic [DATA_WIDTH-1:0]   clip_thresh,
    output logic                    ramping,
    output logic                    cfg_update
);
    import effect_ctrl_pkg::*;

    localparam logic [GAIN_WIDTH-1:0] SW_MAX    = GAIN_WIDTH'((1 << SWITCH_WIDTH) - 1);
    localparam logic [GAIN_WIDTH-1:0] GAIN_UNIT = GAIN_ONE / SW_MAX;

    logic                    rst_meta;
    logic                    rst_int_n;
    logic [SWITCH_WIDTH-1:0] sw_meta;
    logic [SWITCH_WIDTH-1:0] sw_sync;
    logic [GAIN_WIDTH-1:0]   target;
    logic [GAIN_WIDTH-1:0]   gain_nxt;
    logic                    btn_db;
    logic                    press;
    logic                    clip_req;
    logic                    clip_nxt;
    gain_state_t             state;

    // Assert asynchronously, release on a clock edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rst_meta  <= 1'b0;
            rst_int_n <= 1'b0;
        end else begin
            rst_meta  <= 1'b1;
            rst_int_n <= rst_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= sw;
            sw_sync <= sw_meta;
        end
    end

    always_comb begin
        if (sw_sync == '1) target = GAIN_ONE;
        else               target = GAIN_WIDTH'(sw_sync) * GAIN_UNIT;
    end

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk    (clk),
        .rst_n  (rst_int_n),
        .btn    (btn),
        .btn_db (btn_db),
        .press  (press)
    );

`ifdef CLIP_TOGGLE_EN
    logic clip_tog;

    assign clip_req = clip_tog ^ press;

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) clip_tog <= 1'b0;
        else            clip_tog <= clip_req;
    end
`else
    // press can only be high while btn_db is, so this is plain hold-to-clip.
    assign clip_req = btn_db | press;
`endif

    assign clip_nxt    = frame_tick ? clip_req : clip_en;
    assign clip_thresh = CLIP_THRESH;

    // Steps are clamped at the target; a stale direction after a reversal steps nothing.
    always_comb begin
        gain_nxt = gain;
        if (frame_tick && state == RAMP_UP && gain < target)
            gain_nxt = (target - gain > GAIN_STEP) ? gain + GAIN_STEP : target;
        else if (frame_tick && state == RAMP_DOWN && gain > target)
            gain_nxt = (gain - target > GAIN_STEP) ? gain - GAIN_STEP : target;
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state      <= HOLD;
            gain       <= '0;
            clip_en    <= 1'b0;
            ramping    <= 1'b0;
            cfg_update <= 1'b0;
        end else begin
            state      <= gain_dir(gain_nxt, target);
            ramping    <= (gain_dir(gain_nxt, target) != HOLD);
            gain       <= gain_nxt;
            clip_en    <= clip_nxt;
            cfg_update <= (gain_nxt != gain) || (clip_nxt != clip_en);
        end
    end

endmodule

// File: tb/tb_axis_effect_controller.sv
// Scoreboard bench for axis_effect_controller: a cycle-level reference model
// predicts every configuration change, a monitor matches them against cfg_update.
module tb_axis_effect_controller;

    localparam int DEB  = 1500;
    localparam int STEP = 'h010000;
    localparam int ONE  = 'h1000000;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        btn = 1'b0;
    logic [3:0]  sw = 4'h0;
    logic        frame_tick = 1'b0;
    logic [24:0] gain;
    logic        clip_en;
    logic [23:0] clip_thresh;
    logic        ramping;
    logic        cfg_update;

    axis_effect_controller #(
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .btn         (btn),
        .sw          (sw),
        .frame_tick  (frame_tick),
        .gain        (gain),
        .clip_en     (clip_en),
        .clip_thresh (clip_thresh),
        .ramping     (ramping),
        .cfg_update  (cfg_update)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [24:0] g;
        logic        c;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passes = 0;
    int   upd_cnt = 0;

    // reference model state
    int   m_gain, m_dir, m_run;
    bit   m_clip, m_db, m_press, m_tog;
    bit   m_b1, m_b2;
    bit [3:0] m_sw1, m_sw2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: actual=%h required=%h at %0t", name, act, req, $time);
    endtask

    function automatic int tgt(input bit [3:0] s);
        return (s == 4'hF) ? ONE : int'(s) * 'h111111;
    endfunction

    function automatic int sgn_dir(input int g, input int t);
        return (g < t) ? 1 : ((g > t) ? -1 : 0);
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic model_reset();
        m_gain = 0; m_clip = 0; m_db = 0; m_press = 0; m_tog = 0; m_run = 0;
        m_sw1 = sw; m_sw2 = sw; m_b1 = btn; m_b2 = btn;
        m_dir = sgn_dir(0, tgt(sw));
        q.delete();
    endtask

    // Advance the model across one clock edge using the inputs that were present before it.
    task automatic model_edge();
        int t, ng;
        bit req, nc, ndb;
        t = tgt(m_sw2);
`ifdef CLIP_TOGGLE_EN
        req = m_tog ^ m_press;
`else
        req = m_db;
`endif
        ng = m_gain;
        if (frame_tick) begin
            if (m_dir > 0 && m_gain < t)      ng = imin(m_gain + STEP, t);
            else if (m_dir < 0 && m_gain > t) ng = imax(m_gain - STEP, t);
        end
        nc = frame_tick ? req : m_clip;
        ndb = m_db;
        if (m_b2 != m_db) begin
            m_run++;
            if (m_run == DEB) begin
                ndb = m_b2;
                m_run = 0;
            end
        end else begin
            m_run = 0;
        end
        m_press = ndb & ~m_db;
        m_db = ndb;
        m_tog = req;
        m_dir = sgn_dir(ng, t);
        m_sw2 = m_sw1; m_sw1 = sw;
        m_b2 = m_b1;   m_b1 = btn;
        if (ng != m_gain || nc != m_clip) q.push_back('{g: ng[24:0], c: nc});
        m_gain = ng;
        m_clip = nc;
    endtask

    task automatic cycle(input bit tk);
        frame_tick = tk;
        @(posedge clk);
        #1;
        model_edge();
        frame_tick = 1'b0;
    endtask

    task automatic tick_gap();
        repeat ($urandom_range(1, 6)) cycle(1'b0);
        cycle(1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0);
    endtask

    // Monitor: every cfg_update must match the oldest predicted change, and no prediction may be missed.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (resetn && (cfg_update || q.size() != 0)) begin
                chk("cfg_update", {31'b0, cfg_update}, {31'b0, q.size() != 0});
                if (cfg_update) upd_cnt++;
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("gain", 32'(gain), 32'(e.g));
                    chk("clip_en", {31'b0, clip_en}, {31'b0, e.c});
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int u0;
        // 1: reset with full-scale switches and no ticks
        sw = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gain", 32'(gain), 32'h0);
        chk("rst_clip_en", {31'b0, clip_en}, 32'h0);
        chk("rst_ramping", {31'b0, ramping}, 32'h0);
        chk("rst_cfg_update", {31'b0, cfg_update}, 32'h0);
        chk("rst_clip_thresh", 32'(clip_thresh), 32'h0F0000);
        resetn = 1'b1;
        model_reset();
        idle(8);
        chk("t1_gain_frozen", 32'(gain), 32'h0);
        chk("t1_ramping", {31'b0, ramping}, 32'h1);

        // 2: ramp 0 -> 1.0 in 256 ticks
        u0 = upd_cnt;
        repeat (255) tick_gap();
        idle(1);
        chk("t2_gain_255", 32'(gain), 32'h0FF0000);
        chk("t2_ramping_255", {31'b0, ramping}, 32'h1);
        tick_gap();
        idle(2);
        chk("t2_gain_final", 32'(gain), 32'h1000000);
        chk("t2_ramping_final", {31'b0, ramping}, 32'h0);
        chk("t2_update_count", 32'(upd_cnt - u0), 32'd256);

        // 3: reversal after 10 downward steps
        sw = 4'h0;
        idle(4);
        repeat (10) tick_gap();
        idle(1);
        chk("t3_gain_reversal", 32'(gain), 32'h0F60000);
        sw = 4'hF;
        idle(4);
        for (int i = 0; i < 40 && m_gain != ONE; i++) begin
            tick_gap();
            chk("t3_no_overshoot", {31'b0, gain <= 25'h1000000}, 32'h1);
        end
        idle(1);
        chk("t3_gain_back", 32'(gain), 32'h1000000);

        // 4: ramp to a non-multiple target, last step clamped
        sw = 4'h0;
        idle(4);
        for (int i = 0; i < 300 && m_gain != 0; i++) tick_gap();
        sw = 4'h5;
        idle(4);
        repeat (85) tick_gap();
        idle(1);
        chk("t4_gain_85", 32'(gain), 32'h0550000);
        tick_gap();
        idle(1);
        chk("t4_gain_final", 32'(gain), 32'h0555555);
        chk("t4_ramping_final", {31'b0, ramping}, 32'h0);
        tick_gap();
        chk("t4_gain_stays", 32'(gain), 32'h0555555);

        // 5: bouncing button then a clean press
        for (int b = 0; b < 20; b++) begin
            btn = ~btn;
            repeat (1000) cycle($urandom_range(0, 15) == 0);
        end
        chk("t5_no_press_bounce", {31'b0, clip_en}, 32'h0);
        btn = 1'b1;
        idle(DEB + 10);
        chk("t5_clip_waits_tick", {31'b0, clip_en}, 32'h0);
        cycle(1'b1);
        idle(1);
        chk("t5_clip_set", {31'b0, clip_en}, 32'h1);
        btn = 1'b0;
        idle(DEB + 10);
        chk("t5_release_frozen", {31'b0, clip_en}, 32'h1);
        cycle(1'b1);
        idle(1);
`ifdef CLIP_TOGGLE_EN
        chk("t5_release_keeps", {31'b0, clip_en}, 32'h1);
        btn = 1'b1;
        idle(DEB + 10);
        cycle(1'b1);
        idle(1);
        chk("t5_second_press_clears", {31'b0, clip_en}, 32'h0);
        btn = 1'b0;
        idle(DEB + 10);
`else
        chk("t5_release_clears", {31'b0, clip_en}, 32'h0);
`endif
        btn = 1'b1;
        idle(DEB + 10);
        cycle(1'b1);
        idle(1);
        chk("t5_clip_reenabled", {31'b0, clip_en}, 32'h1);

        // random phase: switch changes and dense ticks against the model
        for (int r = 0; r < 15; r++) begin
            sw = 4'($urandom_range(0, 15));
            repeat ($urandom_range(100, 300)) cycle($urandom_range(0, 3) == 0);
            chk("rand_ramping", {31'b0, ramping}, {31'b0, m_dir != 0});
        end

        // 6: asynchronous reset in the middle of a ramp
        sw = 4'h0;
        idle(4);
        for (int i = 0; i < 300 && m_gain != 0; i++) tick_gap();
        sw = 4'hF;
        idle(4);
        repeat (128) tick_gap();
        idle(1);
        chk("t6_gain_mid", 32'(gain), 32'h0800000);
        chk("t6_ramping_mid", {31'b0, ramping}, 32'h1);
        chk("t6_clip_mid", {31'b0, clip_en}, 32'h1);
        #1;
        resetn = 1'b0;
        btn = 1'b0;
        #1;
        chk("t6_rst_gain", 32'(gain), 32'h0);
        chk("t6_rst_clip_en", {31'b0, clip_en}, 32'h0);
        chk("t6_rst_ramping", {31'b0, ramping}, 32'h0);
        chk("t6_rst_cfg_update", {31'b0, cfg_update}, 32'h0);
        q.delete();
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        model_reset();
        idle(8);
        chk("t6_post_gain", 32'(gain), 32'h0);
        chk("t6_post_ramping", {31'b0, ramping}, 32'h1);
        tick_gap();
        idle(2);
        chk("t6_post_step", 32'(gain), 32'h0010000);
        chk("queue_drained", 32'(q.size()), 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
